avst_error_adapter_pipe: RTL and testbench

- Parametrised Avalon-ST error adapter for converting between streaming interfaces with different error signalling, e.g. MAC/DMA paths in the Qsys interconnect.
- Maps an input error vector onto an output error vector through a configurable bit map.
- Optionally makes errors sticky to end-of-packet and counts errored packets.
- Registered output stage with a skid buffer, so in_ready and all out_* are flop-driven.

---
 rtl/avst_error_adapter_pipe.sv | 159 +++++++++++++++
 tb/tb_avst_error_adapter_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_error_adapter_pipe.sv
// ============================================================================
// Module   : avst_error_adapter_pipe
// Purpose  : Avalon-ST error adapter with bit-mapped error translation,
//            optional end-of-packet sticky errors, an errored-packet counter
//            and a registered output stage backed by a one-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avst_error_adapter_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int EMPTY_WIDTH     = 2,
    parameter int IN_ERROR_WIDTH  = 2,
    parameter int OUT_ERROR_WIDTH = 1,
    parameter logic [OUT_ERROR_WIDTH*IN_ERROR_WIDTH-1:0] ERROR_MAP = '1,
    parameter bit STICKY          = 1'b1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       in_ready,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_startofpacket,
    input  logic                       in_endofpacket,
    input  logic [EMPTY_WIDTH-1:0]     in_empty,
    input  logic [IN_ERROR_WIDTH-1:0]  in_error,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_startofpacket,
    output logic                       out_endofpacket,
    output logic [EMPTY_WIDTH-1:0]     out_empty,
    output logic [OUT_ERROR_WIDTH-1:0] out_error,
    input  logic                       clear_count,
    output logic [CNT_WIDTH-1:0]       err_pkt_count
);

    // Packed beat layout, MSB first: data | sop | eop | empty | error
    localparam int c_BEAT_W  = DATA_WIDTH + 2 + EMPTY_WIDTH + OUT_ERROR_WIDTH;
    localparam int c_EOP_POS = OUT_ERROR_WIDTH + EMPTY_WIDTH;
    localparam int c_SOP_POS = c_EOP_POS + 1;

    logic                       in_ready_q;
    logic                       in_ready_d;
    logic                       out_valid_q;
    logic                       out_valid_d;
    logic [c_BEAT_W-1:0]        out_beat_q;
    logic [c_BEAT_W-1:0]        out_beat_d;
    logic                       skid_valid_q;
    logic                       skid_valid_d;
    logic [c_BEAT_W-1:0]        skid_beat_q;
    logic [c_BEAT_W-1:0]        skid_beat_d;
    logic [CNT_WIDTH-1:0]       cnt_q;
    logic [CNT_WIDTH-1:0]       cnt_d;

    logic                       w_accept;
    logic                       w_out_free;
    logic [OUT_ERROR_WIDTH-1:0] w_map_err;
    logic [OUT_ERROR_WIDTH-1:0] w_beat_err;
    logic [c_BEAT_W-1:0]        w_in_beat;

    assign w_accept   = in_valid & in_ready_q;
    assign w_out_free = ~out_valid_q | out_ready;

    for (genvar j = 0; j < OUT_ERROR_WIDTH; j++) begin : g_map
        assign w_map_err[j] = |(in_error & ERROR_MAP[j*IN_ERROR_WIDTH +: IN_ERROR_WIDTH]);
    end

    if (STICKY) begin : g_sticky
        logic [OUT_ERROR_WIDTH-1:0] sticky_q;
        logic [OUT_ERROR_WIDTH-1:0] sticky_d;

        // A SOP beat ignores history, so a packet missing its EOP cannot leak into the next one
        assign w_beat_err = w_map_err | (in_startofpacket ? '0 : sticky_q);

        always_comb begin
            sticky_d = sticky_q;
            if (w_accept) begin
                sticky_d = in_endofpacket ? '0 : w_beat_err;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sticky_q <= '0;
            end else begin
                sticky_q <= sticky_d;
            end
        end
    end else begin : g_no_sticky
        assign w_beat_err = w_map_err;
    end

    assign w_in_beat = {in_data, in_startofpacket, in_endofpacket, in_empty, w_beat_err};

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        if (w_out_free) begin
            // in_ready is low whenever the skid is occupied, so skid and input never compete
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                out_valid_d = 1'b1;
                out_beat_d  = w_in_beat;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = w_in_beat;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (w_accept && in_endofpacket && (|w_beat_err) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
            cnt_q        <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_beat_q[c_BEAT_W-1 -: DATA_WIDTH];
    assign out_startofpacket = out_beat_q[c_SOP_POS];
    assign out_endofpacket   = out_beat_q[c_EOP_POS];
    assign out_empty         = out_beat_q[OUT_ERROR_WIDTH +: EMPTY_WIDTH];
    assign out_error         = out_beat_q[0 +: OUT_ERROR_WIDTH];
    assign err_pkt_count     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_avst_error_adapter_pipe.sv
// ============================================================================
// Module   : tb_avst_error_adapter_pipe
// Purpose  : Self-checking bench for three adapter configurations sharing
//            one stimulus stream, checked against a per-instance beat model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avst_error_adapter_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
        logic [1:0]  err;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [1:0]  in_empty = '0;
    logic [1:0]  in_error = '0;
    logic        out_ready = 1'b0;
    logic        fixed_ready = 1'b1;
    logic        rnd_ready = 1'b0;
    logic        clear_count = 1'b0;

    logic        rdy [3];
    logic        ov [3];
    logic [31:0] od [3];
    logic        osop [3];
    logic        oeop [3];
    logic [1:0]  oemp [3];
    logic [1:0]  oerr [3];
    logic [15:0] cnt [3];

    logic        oerr0_w, oerr2_w;
    logic [1:0]  oerr1_w;
    logic [15:0] cnt0_w, cnt1_w;
    logic [1:0]  cnt2_w;

    assign oerr[0] = {1'b0, oerr0_w};
    assign oerr[1] = oerr1_w;
    assign oerr[2] = {1'b0, oerr2_w};
    assign cnt[0]  = cnt0_w;
    assign cnt[1]  = cnt1_w;
    assign cnt[2]  = {14'd0, cnt2_w};

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    avst_error_adapter_pipe u0 (
        .clk(clk), .reset_n(reset_n), .in_ready(rdy[0]), .in_valid(in_valid),
        .in_data(in_data), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_empty(in_empty), .in_error(in_error), .out_ready(out_ready),
        .out_valid(ov[0]), .out_data(od[0]), .out_startofpacket(osop[0]),
        .out_endofpacket(oeop[0]), .out_empty(oemp[0]), .out_error(oerr0_w),
        .clear_count(clear_count), .err_pkt_count(cnt0_w)
    );

    avst_error_adapter_pipe #(
        .OUT_ERROR_WIDTH(2), .ERROR_MAP(4'b0110), .STICKY(1'b0)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .in_ready(rdy[1]), .in_valid(in_valid),
        .in_data(in_data), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_empty(in_empty), .in_error(in_error), .out_ready(out_ready),
        .out_valid(ov[1]), .out_data(od[1]), .out_startofpacket(osop[1]),
        .out_endofpacket(oeop[1]), .out_empty(oemp[1]), .out_error(oerr1_w),
        .clear_count(clear_count), .err_pkt_count(cnt1_w)
    );

    avst_error_adapter_pipe #(
        .CNT_WIDTH(2)
    ) u2 (
        .clk(clk), .reset_n(reset_n), .in_ready(rdy[2]), .in_valid(in_valid),
        .in_data(in_data), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_empty(in_empty), .in_error(in_error), .out_ready(out_ready),
        .out_valid(ov[2]), .out_data(od[2]), .out_startofpacket(osop[2]),
        .out_endofpacket(oeop[2]), .out_empty(oemp[2]), .out_error(oerr2_w),
        .clear_count(clear_count), .err_pkt_count(cnt2_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam bit          STICKY_M [3] = '{1'b1, 1'b0, 1'b1};
    localparam int          OEW_M    [3] = '{1, 2, 1};
    localparam int unsigned CMAX_M   [3] = '{65535, 65535, 3};

    beat_t       mq [3][8];
    int          hd [3];
    int          tl [3];
    logic [1:0]  s_m [3];
    int unsigned cnt_m [3];
    bit          stall_prev [3];
    bit          started = 1'b0;

    // out_error[j] is set when any input error bit routed to output j is set
    function automatic logic [1:0] map_err(input int k, input logic [1:0] e);
        logic [3:0] mp;
        logic [1:0] r;
        mp = (k == 1) ? 4'b0110 : 4'b0011;
        r  = 2'b00;
        for (int j = 0; j < OEW_M[k]; j++)
            for (int i = 0; i < 2; i++)
                if (mp[j*2+i] && e[i]) r[j] = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            started = 1'b1;
            for (int k = 0; k < 3; k++) begin
                hd[k] = 0; tl[k] = 0; s_m[k] = 2'b00; cnt_m[k] = 0; stall_prev[k] = 1'b0;
            end
        end else if (started) begin
            for (int k = 0; k < 3; k++) begin
                beat_t b;
                bit    err_eop;
                chk($sformatf("count[%0d]", k), 64'(cnt[k]), 64'(cnt_m[k]));
                if (ov[k]) begin
                    if (tl[k] == hd[k]) begin
                        chk($sformatf("phantom_beat[%0d]", k), 64'(ov[k]), 64'd0);
                    end else begin
                        b = mq[k][hd[k] % 8];
                        chk($sformatf("out_data[%0d]", k), 64'(od[k]), 64'(b.d));
                        chk($sformatf("out_sop[%0d]", k), 64'(osop[k]), 64'(b.sop));
                        chk($sformatf("out_eop[%0d]", k), 64'(oeop[k]), 64'(b.eop));
                        chk($sformatf("out_empty[%0d]", k), 64'(oemp[k]), 64'(b.emp));
                        chk($sformatf("out_error[%0d]", k), 64'(oerr[k]), 64'(b.err));
                    end
                    if (out_ready && tl[k] != hd[k]) hd[k]++;
                end else if (tl[k] != hd[k]) begin
                    chk($sformatf("beat_missing[%0d]", k), 64'(ov[k]), 64'd1);
                end
                err_eop = 1'b0;
                if (in_valid && rdy[k]) begin
                    b.d   = in_data;
                    b.sop = in_sop;
                    b.eop = in_eop;
                    b.emp = in_empty;
                    b.err = map_err(k, in_error) | ((STICKY_M[k] && !in_sop) ? s_m[k] : 2'b00);
                    if (STICKY_M[k]) s_m[k] = in_eop ? 2'b00 : b.err;
                    mq[k][tl[k] % 8] = b;
                    tl[k]++;
                    err_eop = in_eop && (b.err != 2'b00);
                    if (tl[k] - hd[k] > 2)
                        chk($sformatf("occupancy[%0d]", k), 64'(tl[k] - hd[k]), 64'd2);
                end
                if (clear_count) cnt_m[k] = 0;
                else if (err_eop && cnt_m[k] < CMAX_M[k]) cnt_m[k]++;
                if (!rdy[k] && out_ready) begin
                    if (stall_prev[k])
                        chk($sformatf("ready_stuck[%0d]", k), 64'(rdy[k]), 64'd1);
                    stall_prev[k] = 1'b1;
                end else begin
                    stall_prev[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] d, input logic sop, input logic eop,
                        input logic [1:0] emp, input logic [1:0] err);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
        in_empty = emp; in_error = err;
        @(negedge clk);
        while (!rdy[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(rdy[0]), 64'd0);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_count", 64'(cnt[0]), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 64'(rdy[0]), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_err [4];
        exp_err[0] = 2'b00; exp_err[1] = 2'b01; exp_err[2] = 2'b01; exp_err[3] = 2'b01;

        fixed_ready = 1'b1;
        do_reset();
        idle(2);

        // Streaming with sticky error from beat 2 onward
        for (int i = 0; i < 4; i++) begin
            send(32'h11 * (i + 1), i == 0, i == 3, 2'd0, (i == 1) ? 2'b10 : 2'b00);
            chk("stream_valid", 64'(ov[0]), 64'd1);
            chk("stream_data", 64'(od[0]), 64'(32'h11 * (i + 1)));
            chk("stream_err", 64'(oerr[0]), 64'(exp_err[i]));
        end
        chk("stream_count", 64'(cnt[0]), 64'd1);
        idle(2);

        // Bit map on the non-sticky instance
        send(32'hA1, 1'b1, 1'b1, 2'd1, 2'b01);
        chk("map_01", 64'(oerr[1]), 64'd2);
        send(32'hA2, 1'b1, 1'b1, 2'd2, 2'b10);
        chk("map_10", 64'(oerr[1]), 64'd1);
        send(32'hA3, 1'b1, 1'b0, 2'd3, 2'b11);
        chk("map_11", 64'(oerr[1]), 64'd3);
        send(32'hA4, 1'b0, 1'b1, 2'd0, 2'b00);
        chk("map_no_carry", 64'(oerr[1]), 64'd0);
        chk("sticky_carry_u0", 64'(oerr[0]), 64'd1);
        idle(3);

        // Random backpressure, random packets
        rnd_ready = 1'b1;
        begin
            bit in_pkt;
            in_pkt = 1'b0;
            for (int i = 0; i < 200; i++) begin
                logic eop;
                eop = ($urandom_range(0, 3) == 0) || (i == 199);
                send($urandom, !in_pkt, eop, 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
                in_pkt = !eop;
            end
        end
        rnd_ready = 1'b0;
        idle(6);

        // SOP without EOP: errored partial packet A, then clean packet B
        do_reset();
        send(32'h100, 1'b1, 1'b0, 2'd0, 2'b01);
        send(32'h101, 1'b0, 1'b0, 2'd0, 2'b00);
        chk("a_sticky", 64'(oerr[0]), 64'd1);
        send(32'h200, 1'b1, 1'b0, 2'd0, 2'b00);
        chk("b_sop_err", 64'(oerr[0]), 64'd0);
        send(32'h201, 1'b0, 1'b1, 2'd0, 2'b00);
        chk("b_eop_err", 64'(oerr[0]), 64'd0);
        chk("b_count", 64'(cnt[0]), 64'd0);
        idle(2);

        // Reset mid-packet discards sticky state
        send(32'h300, 1'b1, 1'b0, 2'd0, 2'b10);
        chk("pre_rst_err", 64'(oerr[0]), 64'd1);
        do_reset();
        send(32'h301, 1'b0, 1'b1, 2'd0, 2'b00);
        chk("post_rst_err", 64'(oerr[0]), 64'd0);
        chk("post_rst_count", 64'(cnt[0]), 64'd0);
        idle(2);

        // Saturating 2-bit counter and clear priority
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(32'h400 + i, 1'b1, 1'b1, 2'd0, 2'b01);
            chk($sformatf("sat_count_%0d", i), 64'(cnt[2]), 64'((i < 3) ? i + 1 : 3));
        end
        chk("wide_count", 64'(cnt[0]), 64'd5);
        clear_count = 1'b1;
        send(32'h500, 1'b1, 1'b1, 2'd0, 2'b11);
        clear_count = 1'b0;
        chk("clear_prio_u2", 64'(cnt[2]), 64'd0);
        chk("clear_prio_u0", 64'(cnt[0]), 64'd0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
